// File: rtl/uart_bus_master.sv
// uart_bus_master: byte-command bridge from a UART receiver to the SoC
// valid/ready memory bus. Parses 'R'/'W' commands with little-endian
// address/data, issues one word access, and returns the result bytes.
module uart_bus_master #(
    parameter int unsigned BYTE_TIMEOUT = 1000000,
    parameter int unsigned BUS_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned ICW = $clog2(BYTE_TIMEOUT) + 1;
    localparam int unsigned BCW = $clog2(BUS_TIMEOUT) + 1;
    localparam logic [ICW-1:0] IDLE_LIMIT = ICW'(BYTE_TIMEOUT - 1);
    localparam logic [BCW-1:0] BUS_LIMIT  = BCW'(BUS_TIMEOUT - 1);

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_UNK   = 8'h3F;
    localparam logic [7:0] RSP_TMO   = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP,
        S_ERR
    } state_t;

    state_t         state, state_nxt;
    logic           is_write, is_write_nxt;
    logic [1:0]     byte_cnt, byte_cnt_nxt;
    logic [31:0]    addr, addr_nxt;
    logic [31:0]    wdata, wdata_nxt;
    logic [31:0]    rdata_buf, rdata_nxt;
    logic [1:0]     resp_idx, resp_idx_nxt;
    logic [1:0]     resp_last, resp_last_nxt;
    logic [1:0]     resp_idx_inc;
    logic [ICW-1:0] idle_cnt, idle_cnt_nxt;
    logic [BCW-1:0] bus_cnt, bus_cnt_nxt;
    logic           mem_valid_nxt;
    logic           tx_valid_nxt;
    logic [7:0]     tx_data_nxt;
    logic           err_busy, err_busy_nxt;

    assign resp_idx_inc = resp_idx + 2'd1;

    // Word-aligned address: low two address bits are dropped on the bus.
    assign mem_addr  = addr & 32'hFFFF_FFFC;
    assign mem_wdata = wdata;
    assign mem_wstrb = (mem_valid && is_write) ? 4'hF : 4'h0;
    // An unknown-command error never claimed the bus, so it stays non-busy.
    assign busy      = (state != S_IDLE) && !((state == S_ERR) && !err_busy);

    // State and datapath registers, cleared by synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= '0;
            addr      <= '0;
            wdata     <= '0;
            rdata_buf <= '0;
            resp_idx  <= '0;
            resp_last <= '0;
            idle_cnt  <= '0;
            bus_cnt   <= '0;
            mem_valid <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            err_busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            is_write  <= is_write_nxt;
            byte_cnt  <= byte_cnt_nxt;
            addr      <= addr_nxt;
            wdata     <= wdata_nxt;
            rdata_buf <= rdata_nxt;
            resp_idx  <= resp_idx_nxt;
            resp_last <= resp_last_nxt;
            idle_cnt  <= idle_cnt_nxt;
            bus_cnt   <= bus_cnt_nxt;
            mem_valid <= mem_valid_nxt;
            tx_valid  <= tx_valid_nxt;
            tx_data   <= tx_data_nxt;
            err_busy  <= err_busy_nxt;
        end
    end

    // Next-state logic: command parsing, bus handshake and response sequencing.
    always_comb begin
        state_nxt     = state;
        is_write_nxt  = is_write;
        byte_cnt_nxt  = byte_cnt;
        addr_nxt      = addr;
        wdata_nxt     = wdata;
        rdata_nxt     = rdata_buf;
        resp_idx_nxt  = resp_idx;
        resp_last_nxt = resp_last;
        idle_cnt_nxt  = idle_cnt;
        bus_cnt_nxt   = bus_cnt;
        mem_valid_nxt = mem_valid;
        tx_valid_nxt  = tx_valid;
        tx_data_nxt   = tx_data;
        err_busy_nxt  = err_busy;

        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
                        state_nxt    = S_ADDR;
                        is_write_nxt = (rx_data == CMD_WRITE);
                        byte_cnt_nxt = '0;
                        idle_cnt_nxt = '0;
                    end else begin
                        state_nxt    = S_ERR;
                        tx_valid_nxt = 1'b1;
                        tx_data_nxt  = RSP_UNK;
                        err_busy_nxt = 1'b0;
                    end
                end
            end

            S_ADDR, S_DATA: begin
                // A byte arriving on the timeout cycle is consumed, not dropped.
                if (rx_valid) begin
                    idle_cnt_nxt = '0;
                    if (state == S_ADDR)
                        addr_nxt[{byte_cnt, 3'b000} +: 8] = rx_data;
                    else
                        wdata_nxt[{byte_cnt, 3'b000} +: 8] = rx_data;
                    if (byte_cnt == 2'd3) begin
                        byte_cnt_nxt = '0;
                        if (state == S_ADDR && is_write) begin
                            state_nxt = S_DATA;
                        end else begin
                            state_nxt     = S_BUS;
                            mem_valid_nxt = 1'b1;
                            bus_cnt_nxt   = '0;
                        end
                    end else begin
                        byte_cnt_nxt = byte_cnt + 2'd1;
                    end
                end else if (idle_cnt == IDLE_LIMIT) begin
                    state_nxt    = S_IDLE;
                    idle_cnt_nxt = '0;
                end else if (idle_cnt != '1) begin
                    idle_cnt_nxt = idle_cnt + 1'b1;
                end
            end

            S_BUS: begin
                if (mem_valid && mem_ready) begin
                    mem_valid_nxt = 1'b0;
                    state_nxt     = S_RESP;
                    tx_valid_nxt  = 1'b1;
                    resp_idx_nxt  = '0;
                    if (is_write) begin
                        tx_data_nxt   = RSP_OK;
                        resp_last_nxt = 2'd0;
                    end else begin
                        rdata_nxt     = mem_rdata;
                        tx_data_nxt   = mem_rdata[7:0];
                        resp_last_nxt = 2'd3;
                    end
                end else if (mem_valid) begin
                    if (bus_cnt == BUS_LIMIT) begin
                        mem_valid_nxt = 1'b0;
                        state_nxt     = S_ERR;
                        tx_valid_nxt  = 1'b1;
                        tx_data_nxt   = RSP_TMO;
                        err_busy_nxt  = 1'b1;
                    end else if (bus_cnt != '1) begin
                        bus_cnt_nxt = bus_cnt + 1'b1;
                    end
                end
            end

            S_RESP: begin
                if (tx_valid && tx_ready) begin
                    if (resp_idx == resp_last) begin
                        tx_valid_nxt = 1'b0;
                        state_nxt    = S_IDLE;
                    end else begin
                        resp_idx_nxt = resp_idx_inc;
                        tx_data_nxt  = rdata_buf[{resp_idx_inc, 3'b000} +: 8];
                    end
                end
            end

            S_ERR: begin
                if (tx_valid && tx_ready) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = S_IDLE;
                    err_busy_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt     = S_IDLE;
                mem_valid_nxt = 1'b0;
                tx_valid_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Debug/bootload bridge: a bus initiator on the SoC valid/ready memory bus, driven by a byte command stream from rx_uart.
- Parses byte commands, issues single-word read or write transactions to any bus responder (BRAM, SDRAM, SPI flash, IO), and returns result bytes to tx_uart.
- Sits beside the CPU as a second master, behind an external arbiter; busy tells the arbiter to grant it the bus.

Parameters:
- BYTE_TIMEOUT, 1000000: idle clk cycles between command bytes before the parser aborts to IDLE.
- BUS_TIMEOUT, 1024: clk cycles mem_valid may stay high without mem_ready before the access is abandoned.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_valid  out  1  byte offered to transmitter
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter idle; byte accepted when tx_valid && tx_ready
- mem_valid  out  1  bus request
- mem_ready  in  1  responder completion, one-cycle pulse
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes; 0 = read
- mem_rdata  in  32  read data, valid when mem_ready=1
- busy  out  1  high from first address byte until the last response byte is accepted

Behaviour:
- Clock clk; reset resetn, synchronous, active-low. In reset: mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, tx_valid=0, tx_data=0, busy=0, state=IDLE, all counters=0. Reset mid-transaction drops mem_valid and tx_valid the next edge, with no completion byte.
- Command bytes:
  - 0x52 'R', then 4 address bytes little-endian.
  - 0x57 'W', then 4 address bytes LE, then 4 data bytes LE.
- mem_addr = {addr[31:2],2'b00}. Low address bits are ignored.
- Writes always use wstrb=4'hF. Reads use 4'h0.
- States:
  - IDLE: on rx byte: 'R' or 'W' -> ADDR (latch cmd, byte_cnt=0). Any other value -> ERR with code 0x3F '?'.
  - ADDR: shift each byte into addr[8*byte_cnt+:8]. After the 4th byte: read -> BUS; write -> DATA (byte_cnt=0).
  - DATA: same shift into wdata. After the 4th byte -> BUS.
  - BUS:
    - mem_valid=1 from the cycle after entry.
    - addr, wdata, and wstrb are stable while mem_valid=1.
    - On the first cycle mem_ready=1: mem_valid=0 at the next edge. A read captures mem_rdata and loads 4 response bytes (rdata[7:0] first). A write loads 1 byte 0x4B 'K'. Then -> RESP.
    - If bus_cnt reaches BUS_TIMEOUT-1 without ready: mem_valid=0 -> ERR with 0x45 'E'.
    - mem_ready seen while mem_valid=0 is ignored.
  - RESP: tx_valid=1 with the current byte. On tx_valid&&tx_ready, advance to the next byte the following cycle. After the last byte is accepted -> IDLE, busy=0.
  - ERR: send the single error byte as in RESP -> IDLE.
- tx_valid and tx_data are stable until accepted. No byte is ever dropped under backpressure.
- rx bytes arriving in BUS, RESP or ERR are discarded. No queueing.
- Inter-byte timeout:
  - In ADDR/DATA, idle_cnt counts cycles since the last rx byte and resets on each rx_valid.
  - At BYTE_TIMEOUT-1 the parser returns to IDLE silently, with busy=0 and no bus access.
  - If a byte arrives in the same cycle as the timeout, the byte wins: it is consumed and the counter resets.
- Latency: write, last data byte to mem_valid = 1 cycle. mem_ready to tx_valid = 1 cycle.
- busy is 1 in ADDR, DATA, BUS, RESP and ERR-after-address. An unknown-command ERR does not assert busy.
- Counters are sized $clog2(param)+1 bits and saturate, never wrap.

Test Plan:
- Write: rx 57 00 00 00 80 EF BE AD DE, ready after 3 cycles -> one access: addr=0x80000000, wdata=0xDEADBEEF, wstrb=F, valid high until ready then low. tx 4B.
- Read: rx 52 07 00 00 10, responder returns 0x12345678 -> addr=0x10000004, wstrb=0. tx bytes 78 56 34 12 in order.
- Backpressure: read with tx_ready held low 50 cycles between bytes -> tx_data is stable while waiting, all 4 bytes are sent exactly once, and busy drops after the last byte.
- Errors:
  - rx 0x41 -> tx 3F, no mem_valid.
  - Read with mem_ready never asserted -> mem_valid low after BUS_TIMEOUT cycles, tx 45.
- Inter-byte timeout: BYTE_TIMEOUT=100. rx 52 00 00, wait 100 cycles, then rx 52 04 00 00 00 -> a single read at 0x00000004, no bus access for the partial command.
- Reset mid-BUS: assert resetn=0 while mem_valid=1 -> next edge mem_valid=0, tx_valid=0, busy=0. A fresh read afterwards works.
